// File: rtl/rtc_pkg.sv
// Shared encodings and per-field limits/addresses for the RTC time/date
// adjust sequencers.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_INC  = 2'd0,
    OP_DEC  = 2'd1,
    OP_LOAD = 2'd2
  } op_e;

  localparam logic [7:0] SEC_ADDR  = 8'h40;
  localparam logic [7:0] SEC_MAX   = 8'h59;
  localparam logic [7:0] SEC_MIN   = 8'h00;
  localparam logic [7:0] MINS_ADDR = 8'h42;
  localparam logic [7:0] MINS_MAX  = 8'h59;
  localparam logic [7:0] MINS_MIN  = 8'h00;
  localparam logic [7:0] HOUR_ADDR = 8'h44;
  localparam logic [7:0] HOUR_MAX  = 8'h23;
  localparam logic [7:0] HOUR_MIN  = 8'h00;
  localparam logic [7:0] DAY_ADDR  = 8'h46;
  localparam logic [7:0] DAY_MAX   = 8'h31;
  localparam logic [7:0] DAY_MIN   = 8'h01;
  localparam logic [7:0] MON_ADDR  = 8'h48;
  localparam logic [7:0] MON_MAX   = 8'h12;
  localparam logic [7:0] MON_MIN   = 8'h01;
  localparam logic [7:0] YEAR_ADDR = 8'h4C;
  localparam logic [7:0] YEAR_MAX  = 8'h99;
  localparam logic [7:0] YEAR_MIN  = 8'h00;

endpackage

// File: rtl/bcd_step.sv
// Combinational packed-BCD step/load with wrap limits; an illegal operand
// yields min_bcd and raises illegal.
module bcd_step
  import rtc_pkg::*;
(
  input  logic [7:0] operand,
  input  op_e        op,
  input  logic [7:0] max_bcd,
  input  logic [7:0] min_bcd,
  output logic [7:0] result,
  output logic       illegal
);

  logic [3:0] hi, lo;
  assign hi = operand[7:4];
  assign lo = operand[3:0];

  always_comb begin
    illegal = (hi > 4'd9) || (lo > 4'd9) || (operand < min_bcd) || (operand > max_bcd);
    result  = operand;
    case (op)
      OP_INC: begin
        if (operand == max_bcd)  result = min_bcd;
        else if (lo == 4'd9)     result = {hi + 4'd1, 4'd0};
        else                     result = {hi, lo + 4'd1};
      end
      OP_DEC: begin
        if (operand == min_bcd)  result = max_bcd;
        else if (lo == 4'd0)     result = {hi - 4'd1, 4'd9};
        else                     result = {hi, lo - 4'd1};
      end
      default: result = operand;
    endcase
    if (illegal) result = min_bcd;
  end

endmodule

// File: rtl/rtc_field_adjust.sv
// Single RTC field adjust sequencer: edge-detected step/load request, BCD
// compute, then acknowledged address and data write phases.
module rtc_field_adjust
  import rtc_pkg::*;
#(
  parameter logic [7:0] FIELD_ADDR = 8'h42,
  parameter logic [7:0] MAX_BCD    = 8'h59,
  parameter logic [7:0] MIN_BCD    = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       up,
  input  logic       down,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] field_in,
  input  logic       bus_ack,
  output logic       a_d,
  output logic       w_r,
  output logic [7:0] bus_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [7:0] opnd_q, opnd_d, nxt_q, nxt_d, bus_out_q, bus_out_d;
  logic       up_q, up_d, down_q, down_d, load_q, load_d;
  logic       a_d_q, a_d_d, w_r_q, w_r_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [7:0] step_res;
  logic       step_ill;
  logic       up_rise, down_rise, load_rise;

  assign up_rise   = up   & ~up_q;
  assign down_rise = down & ~down_q;
  assign load_rise = load & ~load_q;

  bcd_step u_step (
    .operand (opnd_q),
    .op      (op_q),
    .max_bcd (MAX_BCD),
    .min_bcd (MIN_BCD),
    .result  (step_res),
    .illegal (step_ill)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    nxt_d     = nxt_q;
    a_d_d     = a_d_q;
    w_r_d     = w_r_q;
    bus_out_d = bus_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    up_d      = up;
    down_d    = down;
    load_d    = load;
    case (state_q)
      ST_IDLE: begin
        // Simultaneous up/down rises cancel; load always wins.
        if (load_rise || (up_rise ^ down_rise)) begin
          op_d    = load_rise ? OP_LOAD : (up_rise ? OP_INC : OP_DEC);
          opnd_d  = load_rise ? load_val : field_in;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        nxt_d     = step_res;
        if (step_ill) err_d = 1'b1;
        a_d_d     = 1'b0;
        w_r_d     = 1'b1;
        bus_out_d = FIELD_ADDR;
        state_d   = ST_ADDR;
      end
      ST_ADDR: begin
        if (bus_ack) begin
          a_d_d     = 1'b1;
          bus_out_d = nxt_q;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus_ack) begin
          a_d_d     = 1'b0;
          w_r_d     = 1'b0;
          bus_out_d = 8'h00;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable) begin
      state_d   = ST_IDLE;
      a_d_d     = 1'b0;
      w_r_d     = 1'b0;
      bus_out_d = 8'h00;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      up_d      = 1'b0;
      down_d    = 1'b0;
      load_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_INC;
      opnd_q    <= 8'h00;
      nxt_q     <= 8'h00;
      a_d_q     <= 1'b0;
      w_r_q     <= 1'b0;
      bus_out_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      nxt_q     <= nxt_d;
      a_d_q     <= a_d_d;
      w_r_q     <= w_r_d;
      bus_out_q <= bus_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      up_q      <= up_d;
      down_q    <= down_d;
      load_q    <= load_d;
    end
  end

  assign a_d     = a_d_q;
  assign w_r     = w_r_q;
  assign bus_out = bus_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_rtc_field_adjust.sv
// Scoreboard bench: minutes and day instances; expected writes are queued at
// stimulus time and checked by per-instance monitors on each done pulse.
module tb_rtc_field_adjust;
  import rtc_pkg::*;

  logic clk = 1'b0;
  logic reset, enable, bus_ack;
  logic up0, down0, load0, up1, down1, load1;
  logic [7:0] lv0, fi0, lv1, fi1, bo0, bo1;
  logic a_d0, w_r0, busy0, done0, err0;
  logic a_d1, w_r1, busy1, done1, err1;

  always #5 clk = ~clk;

  rtc_field_adjust #(.FIELD_ADDR(MINS_ADDR), .MAX_BCD(MINS_MAX), .MIN_BCD(MINS_MIN)) u_min (
    .clk(clk), .reset(reset), .enable(enable), .up(up0), .down(down0), .load(load0),
    .load_val(lv0), .field_in(fi0), .bus_ack(bus_ack), .a_d(a_d0), .w_r(w_r0),
    .bus_out(bo0), .busy(busy0), .done(done0), .err(err0));

  rtc_field_adjust #(.FIELD_ADDR(DAY_ADDR), .MAX_BCD(DAY_MAX), .MIN_BCD(DAY_MIN)) u_day (
    .clk(clk), .reset(reset), .enable(enable), .up(up1), .down(down1), .load(load1),
    .load_val(lv1), .field_in(fi1), .bus_ack(bus_ack), .a_d(a_d1), .w_r(w_r1),
    .bus_out(bo1), .busy(busy1), .done(done1), .err(err1));

  typedef struct packed {logic [7:0] addr; logic [7:0] data; logic err;} exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  logic [7:0] ca0, cd0, ca1, cd1;
  int total = 0, bad = 0, ndone0 = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (w_r0 && !a_d0) ca0 = bo0;
    if (w_r0 && a_d0)  cd0 = bo0;
    if (done0) begin
      ndone0++;
      if (q0.size() == 0) chk("min_unexpected_done", 16'd1, 16'd0);
      else begin
        e0 = q0.pop_front();
        chk("min_addr", {8'h0, ca0}, {8'h0, e0.addr});
        chk("min_data", {8'h0, cd0}, {8'h0, e0.data});
        chk("min_err", {15'h0, err0}, {15'h0, e0.err});
      end
    end
  end

  always @(negedge clk) begin
    if (w_r1 && !a_d1) ca1 = bo1;
    if (w_r1 && a_d1)  cd1 = bo1;
    if (done1) begin
      if (q1.size() == 0) chk("day_unexpected_done", 16'd1, 16'd0);
      else begin
        e1 = q1.pop_front();
        chk("day_addr", {8'h0, ca1}, {8'h0, e1.addr});
        chk("day_data", {8'h0, cd1}, {8'h0, e1.data});
        chk("day_err", {15'h0, err1}, {15'h0, e1.err});
      end
    end
  end

  task automatic req(input bit d, input logic [7:0] fld, input logic [7:0] lv,
                     input bit u, input bit dn, input bit ld);
    @(negedge clk);
    if (!d) begin fi0 = fld; lv0 = lv; up0 = u; down0 = dn; load0 = ld; end
    else    begin fi1 = fld; lv1 = lv; up1 = u; down1 = dn; load1 = ld; end
    @(negedge clk);
    up0 = 0; down0 = 0; load0 = 0; up1 = 0; down1 = 0; load1 = 0;
  endtask

  task automatic wait_idle(input bit d);
    int n = 0;
    while ((d ? busy1 : busy0) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("idle_timeout", 16'd1, 16'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_wr0();
    int n = 0;
    while (!w_r0 && n < 10) begin @(negedge clk); n++; end
    if (n >= 10) chk("wr_timeout", 16'd1, 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int d0;
    bit saw;
    reset = 0; enable = 1; bus_ack = 1;
    up0 = 0; down0 = 0; load0 = 0; lv0 = 0; fi0 = 0;
    up1 = 0; down1 = 0; load1 = 0; lv1 = 0; fi1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_min", {3'b0, a_d0, w_r0, bo0, busy0, done0, err0}, 16'h0);
    chk("rst_day", {3'b0, a_d1, w_r1, bo1, busy1, done1, err1}, 16'h0);
    reset = 1;
    @(negedge clk);

    // minutes: wraps and nibble carries/borrows
    q0.push_back('{8'h42, 8'h00, 1'b0}); req(0, 8'h59, 8'h00, 1, 0, 0); wait_idle(0);
    q0.push_back('{8'h42, 8'h29, 1'b0}); req(0, 8'h30, 8'h00, 0, 1, 0); wait_idle(0);
    q0.push_back('{8'h42, 8'h59, 1'b0}); req(0, 8'h00, 8'h00, 0, 1, 0); wait_idle(0);
    q0.push_back('{8'h42, 8'h10, 1'b0}); req(0, 8'h09, 8'h00, 1, 0, 0); wait_idle(0);
    q0.push_back('{8'h42, 8'h00, 1'b1}); req(0, 8'h5A, 8'h00, 1, 0, 0); wait_idle(0);
    q0.push_back('{8'h42, 8'h37, 1'b0}); req(0, 8'h00, 8'h37, 0, 0, 1); wait_idle(0);

    // day: MIN=01 wrap, illegal load, sticky err cleared by next request
    q1.push_back('{8'h46, 8'h31, 1'b0}); req(1, 8'h01, 8'h00, 0, 1, 0); wait_idle(1);
    q1.push_back('{8'h46, 8'h01, 1'b1}); req(1, 8'h00, 8'h3A, 0, 0, 1); wait_idle(1);
    chk("day_err_sticky", {15'h0, err1}, 16'd1);
    q1.push_back('{8'h46, 8'h16, 1'b0}); req(1, 8'h15, 8'h00, 1, 0, 0); wait_idle(1);
    chk("day_err_cleared", {15'h0, err1}, 16'd0);
    q1.push_back('{8'h46, 8'h01, 1'b0}); req(1, 8'h31, 8'h00, 1, 0, 0); wait_idle(1);

    // ack withheld in ADDR for 5 cycles
    bus_ack = 0;
    q0.push_back('{8'h42, 8'h13, 1'b0}); req(0, 8'h12, 8'h00, 1, 0, 0);
    wait_wr0();
    for (int i = 0; i < 5; i++) begin
      chk("ack_hold", {5'b0, a_d0, w_r0, bo0, done0}, {5'b0, 1'b0, 1'b1, 8'h42, 1'b0});
      @(negedge clk);
    end
    bus_ack = 1;
    wait_idle(0);

    // simultaneous up and down: no write
    saw = 0;
    req(0, 8'h20, 8'h00, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      if (w_r0 || busy0) saw = 1;
      @(negedge clk);
    end
    chk("updown_nowrite", {15'h0, saw}, 16'd0);

    // second up while busy is dropped
    d0 = ndone0;
    q0.push_back('{8'h42, 8'h21, 1'b0});
    @(negedge clk); fi0 = 8'h20; up0 = 1;
    @(negedge clk); up0 = 0;
    @(negedge clk); up0 = 1;
    @(negedge clk); up0 = 0;
    wait_idle(0);
    repeat (4) @(negedge clk);
    chk("busy_ignore_one_done", 16'(ndone0 - d0), 16'd1);

    // enable dropped in DATA
    d0 = ndone0;
    bus_ack = 0;
    req(0, 8'h20, 8'h00, 1, 0, 0);
    wait_wr0();
    bus_ack = 1;
    @(negedge clk);
    chk("abort_in_data", {15'h0, a_d0}, 16'd1);
    enable = 0;
    @(negedge clk);
    chk("abort_outs", {3'b0, a_d0, w_r0, bo0, busy0, done0, err0}, 16'h0);
    enable = 1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", 16'(ndone0 - d0), 16'd0);

    // asynchronous reset mid-ADDR
    bus_ack = 0;
    req(0, 8'h20, 8'h00, 1, 0, 0);
    wait_wr0();
    #2 reset = 0;
    #1 chk("async_rst", {3'b0, a_d0, w_r0, bo0, busy0, done0, err0}, 16'h0);
    @(negedge clk);
    reset = 1; bus_ack = 1;
    repeat (5) @(negedge clk);

    chk("min_queue_empty", 16'(q0.size()), 16'd0);
    chk("day_queue_empty", 16'(q1.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_field_adjust.md
Name: rtc_field_adjust

Overview:
- Parametrised single-field adjust-and-write sequencer for the RTC time/date registers (seconds, minutes, hours, day, month, year).
- On an up/down step or a direct load request, it computes the new packed-BCD value with per-field wrap limits, then drives an address phase and a data phase onto the shared RTC bus.
- Each bus phase is held until the bus controller acknowledges it.
- One instance per field; it sits between the push-button/VGA edit logic and the RTC bus controller.

Parameters:
- FIELD_ADDR, 8'h42, RTC register address driven in the address phase.
- MAX_BCD, 8'h59, highest legal packed-BCD value for the field.
- MIN_BCD, 8'h00, lowest legal packed-BCD value (8'h01 for day/month).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- enable  in  1  block enable; 0 aborts any operation and forces IDLE.
- up  in  1  increment request (level; acted on at its rising edge).
- down  in  1  decrement request (level; acted on at its rising edge).
- load  in  1  direct-set request (rising edge).
- load_val  in  8  packed-BCD value for load.
- field_in  in  8  current packed-BCD field value read from the RTC.
- bus_ack  in  1  bus controller accepts the current phase.
- a_d  out  1  0 = address phase, 1 = data phase.
- w_r  out  1  1 = write cycle active.
- bus_out  out  8  address or data byte.
- busy  out  1  high from CALC through DATA.
- done  out  1  one-cycle pulse when the data phase is acknowledged.
- err  out  1  sticky; set on an illegal BCD operand, cleared by the next accepted request.

Behaviour:
- Reset (reset=0) or enable=0: state=IDLE, a_d=0, w_r=0, bus_out=8'h00, busy=0, done=0, err=0, and all edge-detect registers cleared.
- Edge detect: up/down/load are registered each cycle, and a request is the 0->1 transition. Edges that arrive while busy=1 are ignored; they are neither queued nor replayed.
- Request priority in IDLE: load > (up xor down). up and down rising in the same cycle is a no-op: stay IDLE, no write.
- State IDLE:
  - On an accepted request, latch the operand: field_in for a step, load_val for a load.
  - Go to CALC and set busy=1.
- State CALC (1 cycle): compute next_val.
  - Increment: if operand==MAX_BCD, result is MIN_BCD. Otherwise, a low nibble of 9 becomes 0 and the high nibble is incremented; any other low nibble is incremented.
  - Decrement: if operand==MIN_BCD, result is MAX_BCD. Otherwise, a low nibble of 0 becomes 9 and the high nibble is decremented; any other low nibble is decremented.
  - Load: result is load_val.
  - Illegal operand: either nibble >9, or the value lies outside [MIN_BCD, MAX_BCD]. Result is MIN_BCD and err=1. The write still proceeds.
  - Then go to ADDR.
- State ADDR: a_d=0, w_r=1, bus_out=FIELD_ADDR. Held until bus_ack=1, then go to DATA.
- State DATA: a_d=1, w_r=1, bus_out=next_val. Held until bus_ack=1; then done=1 for exactly one cycle and go to IDLE.
  - On return to IDLE: w_r=0, a_d=0, bus_out=8'h00, busy=0.
- Latency: with bus_ack tied high, done arrives 4 cycles after the request edge is registered (CALC, ADDR, DATA, done).
- bus_ack while in IDLE or CALC is ignored.
- enable dropped mid-ADDR/DATA: next cycle state=IDLE, outputs at reset values, no done.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package rtc_pkg:
  - state encoding for IDLE/CALC/ADDR/DATA (2 bits);
  - operation codes OP_INC/OP_DEC/OP_LOAD;
  - the per-field limit and address constants for seconds, minutes, hours, day, month and year.
- One natural sub-module, bcd_step: purely combinational. Inputs operand, op, MAX/MIN; outputs result and illegal flag. It is reused by the alarm/timer field blocks.

Test Plan:
- Minutes instance, field_in=8'h59, up pulse, bus_ack=1 → bus_out 8'h42 (a_d=0, w_r=1), then 8'h00 (a_d=1, w_r=1), done pulse, err=0.
- field_in=8'h30, down pulse → data 8'h29. field_in=8'h00, down → data 8'h59.
- Day instance (MIN=8'h01, MAX=8'h31): field_in=8'h01, down → 8'h31. load with load_val=8'h3A → data 8'h01 and err=1. The next valid up clears err.
- bus_ack held low 5 cycles in ADDR → a_d/w_r/bus_out stable for all 5 cycles, no done; ack then proceeds to DATA normally.
- up and down rise in the same cycle → no w_r assertion. A second up during busy is ignored, giving exactly one done.
- enable→0 in DATA → IDLE next cycle, w_r=0, no done. reset=0 mid-ADDR → all outputs 0 asynchronously.
